// File: rtl/shift_arbiter_seq.sv
// -----------------------------------------------------------------------------
// shift_arbiter_seq
//
// Shares one 16-bit combinational shifter (mode 0 = SLL, mode 1 = SRA,
// 4-bit amount) between two requesters: req0 (EX-stage ALU) and req1
// (load-alignment unit). Round-robin arbitration with valid/ready on both
// requesters, a two-pass rotate-right sequenced through the single shifter,
// and a registered response held under backpressure.
//
// Optional feature macro: SHIFT_ARB_ROR_EN
//   defined   : op 2'b10 performs ROR as SLL(16-amt) then masked SRA(amt)
//   undefined : op 2'b10 is reserved (data returned unchanged, single pass);
//               the PASS2 state and the partial register are not built.
//
// Ports
//   clk                      system clock, rising edge
//   rst_n                    synchronous active-low reset
//   reqN_valid / reqN_ready  request handshake for requester N (0 or 1)
//   reqN_data [15:0]         operand
//   reqN_amt  [3:0]          shift amount
//   reqN_op   [1:0]          00 SLL, 01 SRA, 10 ROR, 11 reserved
//   resp_valid / resp_ready  response handshake
//   resp_data [15:0]         result
//   resp_id                  requester that issued the result
// -----------------------------------------------------------------------------

module shift_arbiter_seq_shifter (
  input  logic [15:0] data_i,
  input  logic [3:0]  amt_i,
  input  logic        mode_i,
  output logic [15:0] result_o
);

  // Mode 0 is a logical left shift, mode 1 an arithmetic right shift.
  always_comb begin
    if (mode_i == 1'b0) begin
      result_o = data_i << amt_i;
    end else begin
      result_o = $unsigned($signed(data_i) >>> amt_i);
    end
  end

endmodule

module shift_arbiter_seq #(
  parameter logic RR_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_data,
  input  logic [3:0]  req0_amt,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_data,
  input  logic [3:0]  req1_amt,
  input  logic [1:0]  req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_id
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS1 = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd3;
  localparam logic [1:0] OP_SLL   = 2'b00;
  localparam logic [1:0] OP_SRA   = 2'b01;
`ifdef SHIFT_ARB_ROR_EN
  localparam logic [1:0] ST_PASS2 = 2'd2;
  localparam logic [1:0] OP_ROR   = 2'b10;
`endif

  logic [1:0]  state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  amt_q, amt_d;
  logic [1:0]  op_q, op_d;
  logic        id_q, id_d;
  logic        resp_valid_q, resp_valid_d;
  logic [15:0] resp_data_q, resp_data_d;
  logic        resp_id_q, resp_id_d;
`ifdef SHIFT_ARB_ROR_EN
  logic [15:0] partial_q, partial_d;
`endif

  logic        gnt0_s, gnt1_s;
  logic        sh_mode_s;
  logic [3:0]  sh_amt_s;
  logic [15:0] sh_out_s;

  shift_arbiter_seq_shifter u_shifter (
    .data_i   (data_q),
    .amt_i    (sh_amt_s),
    .mode_i   (sh_mode_s),
    .result_o (sh_out_s)
  );

  // Round-robin grant: on a tie the requester that is not the pointer wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst_n && (state_q == ST_IDLE)) begin
      if (req0_valid && req1_valid) begin
        gnt0_s = ptr_q;
        gnt1_s = ~ptr_q;
      end else begin
        gnt0_s = req0_valid;
        gnt1_s = req1_valid;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;

  // Shifter control; inputs are don't-care outside the pass states.
  always_comb begin
    sh_mode_s = 1'b0;
    sh_amt_s  = amt_q;
    case (state_q)
      ST_PASS1: begin
        if (op_q == OP_SRA) begin
          sh_mode_s = 1'b1;
`ifdef SHIFT_ARB_ROR_EN
        end else if (op_q == OP_ROR) begin
          // First ROR pass moves the low bits up: left by (16-amt) mod 16.
          sh_amt_s = 4'd0 - amt_q;
`endif
        end else begin
          sh_mode_s = 1'b0;
        end
      end
`ifdef SHIFT_ARB_ROR_EN
      ST_PASS2: begin
        sh_mode_s = 1'b1;
      end
`endif
      default: begin
        sh_mode_s = 1'b0;
      end
    endcase
  end

  // Sequencer next-state: accept, one or two shifter passes, then hold.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    data_d       = data_q;
    amt_d        = amt_q;
    op_d         = op_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
`ifdef SHIFT_ARB_ROR_EN
    partial_d    = partial_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt0_s || gnt1_s) begin
          data_d  = gnt1_s ? req1_data : req0_data;
          amt_d   = gnt1_s ? req1_amt  : req0_amt;
          op_d    = gnt1_s ? req1_op   : req0_op;
          id_d    = gnt1_s;
          ptr_d   = gnt1_s;
          state_d = ST_PASS1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PASS1: begin
        state_d      = ST_HOLD;
        resp_valid_d = 1'b1;
        resp_id_d    = id_q;
        if ((op_q == OP_SLL) || (op_q == OP_SRA)) begin
          resp_data_d = sh_out_s;
`ifdef SHIFT_ARB_ROR_EN
        end else if ((op_q == OP_ROR) && (amt_q != 4'd0)) begin
          partial_d    = sh_out_s;
          resp_valid_d = 1'b0;
          resp_id_d    = resp_id_q;
          state_d      = ST_PASS2;
`endif
        end else begin
          resp_data_d = data_q;
        end
      end
`ifdef SHIFT_ARB_ROR_EN
      ST_PASS2: begin
        // Masking the SRA result turns it into a logical right shift.
        resp_data_d  = partial_q | (sh_out_s & (16'hFFFF >> amt_q));
        resp_valid_d = 1'b1;
        resp_id_d    = id_q;
        state_d      = ST_HOLD;
      end
`endif
      ST_HOLD: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= RR_INIT;
      data_q       <= 16'h0000;
      amt_q        <= 4'd0;
      op_q         <= 2'b00;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 16'h0000;
      resp_id_q    <= 1'b0;
`ifdef SHIFT_ARB_ROR_EN
      partial_q    <= 16'h0000;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      data_q       <= data_d;
      amt_q        <= amt_d;
      op_q         <= op_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
`ifdef SHIFT_ARB_ROR_EN
      partial_q    <= partial_d;
`endif
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

endmodule

// File: doc/shift_arbiter_seq.md
Name: shift_arbiter_seq

Overview:
- Shares one 16-bit combinational Shifter (SLL/SRA, 4-bit amount, Mode 0=SLL, 1=SRA) between two requesters: req0 is the EX-stage ALU, req1 is the load-alignment unit.
- Round-robin arbitration with valid/ready handshakes on both requesters.
- Sequences a two-pass rotate-right (ROR) through the single shifter.
- Registered response with backpressure. The Shifter is instantiated inside this block.

Parameters:
- RR_INIT, 1'b1: reset value of the last-grant pointer. The default makes req0 win the first tie.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_data  in  16  operand
- req0_amt  in  4  shift amount
- req0_op  in  2  00 SLL, 01 SRA, 10 ROR, 11 reserved
- req1_valid/req1_ready/req1_data/req1_amt/req1_op  same as req0, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  16  result
- resp_id  out  1  requester that issued the result

Behaviour:
- States: IDLE, PASS1, PASS2, HOLD.
- Reset: state IDLE, pointer=RR_INIT, resp_valid=0, resp_data=0, resp_id=0. req*_ready is forced 0 while rst_n=0.
- Readies (combinational):
  - req*_ready is high only in IDLE.
  - Only one ready is asserted per cycle.
  - Both valid: grant the requester that is not the pointer. One valid: grant it.
  - A ready never asserts without its valid.
- Accept = valid && ready at edge T. On accept: capture data, amt, op and id; set pointer=id; go to PASS1.
- PASS1 (cycle T+1):
  - SLL: shifter Mode=0, amt. Register result; go to HOLD.
  - SRA: shifter Mode=1, amt. Register result; go to HOLD.
  - ROR, amt==0: register data unchanged; go to HOLD.
  - ROR, amt!=0: shifter Mode=0, amount (16-amt) mod 16. Store to partial register; go to PASS2.
  - Reserved op: register data unchanged; go to HOLD.
- PASS2 (cycle T+2, ROR only):
  - Shifter Mode=1, amt. Mask = 16'hFFFF >> amt (logical).
  - Result = partial | (sra_out & mask). Go to HOLD.
- HOLD:
  - resp_valid=1; resp_data and resp_id stable until resp_valid && resp_ready.
  - On handshake: resp_valid=0 next cycle; go to IDLE.
- Latency from accept edge to resp_valid: 2 cycles single-pass, 3 cycles ROR (amt!=0).
- Throughput: next accept is no earlier than the cycle after the response handshake.
- Backpressure: resp_ready=0 holds HOLD indefinitely. No new accepts during that time.
- Requester that drops valid before its ready: no state change, no pointer change.
- Reset mid-operation (any state): operation discarded, no response issued, all outputs return to reset values on the next edge.
- Shifter inputs are don't-care in IDLE and HOLD.
- All arithmetic is 16-bit; no carries leave the block.

Optional Feature:
- Macro: SHIFT_ARB_ROR_EN.
- Defined: op 10 executes the two-pass ROR described above.
- Undefined:
  - op 10 is treated as reserved: single pass, data returned unchanged, 2-cycle latency.
  - PASS2 state and partial register are not built.

Test Plan:
- req0 SLL data=0x0003 amt=15, resp_ready=1 -> accept at T, resp_valid at T+2, resp_data=0x8000, resp_id=0.
- req1 SRA data=0x8000 amt=3 -> resp_data=0xF000, resp_id=1, latency 2.
- req0 ROR data=0x8001 amt=4 (macro on) -> PASS2 visited, resp_data=0x1800 at T+3. Same op with macro off -> 0x8001 at T+2.
- Both requesters continuously valid after reset -> grants alternate 0,1,0,1. A tie after a lone req1 grant goes to req0.
- resp_ready held 0 for 5 cycles in HOLD -> resp_data stable, both readies 0. On release, one handshake occurs, then IDLE.
- rst_n low during PASS2 of an ROR -> no resp_valid pulse. After release, pointer=RR_INIT and the next tie goes to req0.
